sram_port_arbiter: RTL and testbench
====================================

Name: sram_port_arbiter

Overview:
- Shares the single read/write port of the sky130 1 KiB SRAM macro (32x256, byte write mask) between two requesters.
- Accepts one request per access slot through a valid/ready handshake, arbitrates round-robin, and drives the macro's active-low chip-select and write-enable from registers.
- Captures read data in a register and returns it to the requester that issued the access.
- Sits between the project top-level pin logic and the macro instance; the macro's second (read-only) port stays tied off.

Parameters:
- AW, 8, SRAM address width (256 words).
- DW, 32, SRAM data width.
- MW, DW/8 = 4, write-mask width (one bit per byte).

Ports:
- clk  in  1  clock; also drives the macro's clk0.
- rst  in  1  synchronous reset, active-high.
- req_valid  in  2  per-requester request valid (bit i = requester i).
- req_ready  out  2  per-requester accept; one-hot or zero.
- req_we  in  2  1 = write, 0 = read, per requester.
- req_addr  in  2*AW  requester i at bits [i*AW +: AW].
- req_wmask  in  2*MW  requester i at bits [i*MW +: MW].
- req_wdata  in  2*DW  requester i at bits [i*DW +: DW].
- rsp_valid  out  2  one-cycle completion pulse to the originating requester (reads and writes).
- rsp_rdata  out  DW  registered read data; valid with rsp_valid on a read.
- busy  out  1  high while state != IDLE.
- sram_csb  out  1  to macro csb0, active-low.
- sram_web  out  1  to macro web0, active-low.
- sram_wmask  out  MW  to macro wmask0.
- sram_addr  out  AW  to macro addr0.
- sram_din  out  DW  to macro din0.
- sram_dout  in  DW  from macro dout0.

Behaviour:
- States: IDLE, ACCESS, CAPTURE; state register is one-hot or binary.
- IDLE:
  - If any req_valid is set, the winner's req_ready is high combinationally.
  - On the accepting edge, register the winner's addr, wmask, wdata and we into the sram_* registers; set sram_csb=0 and sram_web=~we; record the owner; go to ACCESS.
- ACCESS (1 cycle):
  - Macro samples the command at the end of this cycle.
  - Next edge: sram_csb=1, sram_web=1; go to CAPTURE.
- CAPTURE (1 cycle):
  - sram_dout is valid during this cycle.
  - For a read, rsp_rdata <= sram_dout at the end of the cycle; for a write, rsp_rdata holds its value.
  - Next edge: rsp_valid[owner]=1 for exactly one cycle; go to IDLE.
- Timing: request accepted in cycle T0 gives rsp_valid in T3. IDLE in T3 may accept a new request, so throughput is 1 access per 3 cycles.
- req_ready is 0 in ACCESS and CAPTURE, so there are no accepts while busy.
- Round-robin arbitration:
  - last_grant register; reset value 1, so requester 0 wins the first tie.
  - Both valid: grant the requester that is not last_grant.
  - One valid: grant it.
  - last_grant updates on every accept.
- The requester must hold req_* stable while req_valid=1 and req_ready=0; dropping req_valid before acceptance is allowed and causes no access.
- Reset values: state=IDLE, sram_csb=1, sram_web=1, sram_addr=0, sram_din=0, sram_wmask=0, rsp_valid=0, rsp_rdata=0, last_grant=1, owner=0, busy=0.
- Reset mid-operation: all of the above apply at the next edge. An in-flight access is abandoned with no rsp_valid. A write already sampled by the macro may have completed; no retry.
- rsp_rdata holds its last read value until the next read capture.
- Unused address/data bits: none; widths match the macro exactly.

Optional Feature:
- Macro: SRAM_ARB_FIXED_PRIO_EN.
- Defined: fixed priority; requester 0 always wins when both are valid. last_grant is not implemented.
- Undefined: round-robin as described above.

Test Plan:
1. Reset, then requester 0 writes addr 0x05, wdata 0xDEADBEEF, wmask 4'hF; then requester 1 reads 0x05 -> sram_csb low in exactly one cycle per access; rsp_valid=2'b01 at T3 of the write; rsp_valid=2'b10 at T3 of the read with rsp_rdata=0xDEADBEEF.
2. Partial write: requester 0 writes 0x11223344 mask 4'hF to 0x10, then 0xAABBCCDD mask 4'b0001, then reads 0x10 -> rsp_rdata=0x112233DD.
3. Both requesters hold valid reads continuously -> grants alternate 0,1,0,1; accepts are 3 cycles apart; rsp_valid alternates 01,10.
4. With SRAM_ARB_FIXED_PRIO_EN defined, same stimulus as scenario 3 -> requester 0 is granted every slot and requester 1 is starved while requester 0 remains valid.
5. Assert rst during ACCESS of a read -> next cycle sram_csb=1, busy=0, state IDLE; no rsp_valid pulse; the next request is accepted normally and granted to requester 0 on a tie.
6. Requester 1 raises valid and drops it before grant while requester 0 is being served -> no access is issued for requester 1 and rsp_valid[1] stays 0.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// Two-requester arbiter for the single RW port of the sky130 32x256 SRAM macro.
// Build option: define SRAM_ARB_FIXED_PRIO_EN for fixed priority (requester 0 wins ties).
module sram_port_arbiter #(
    parameter int AW = 8,
    parameter int DW = 32,
    parameter int MW = DW / 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        req_valid,
    output logic [1:0]        req_ready,
    input  logic [1:0]        req_we,
    input  logic [2*AW-1:0]   req_addr,
    input  logic [2*MW-1:0]   req_wmask,
    input  logic [2*DW-1:0]   req_wdata,
    output logic [1:0]        rsp_valid,
    output logic [DW-1:0]     rsp_rdata,
    output logic              busy,
    output logic              sram_csb,
    output logic              sram_web,
    output logic [MW-1:0]     sram_wmask,
    output logic [AW-1:0]     sram_addr,
    output logic [DW-1:0]     sram_din,
    input  logic [DW-1:0]     sram_dout
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACCESS  = 2'd1,
        CAPTURE = 2'd2
    } state_t;

    state_t          state_q, state_d;
    logic            csb_q, csb_d;
    logic            web_q, web_d;
    logic [MW-1:0]   wmask_q, wmask_d;
    logic [AW-1:0]   addr_q, addr_d;
    logic [DW-1:0]   din_q, din_d;
    logic [1:0]      rsp_valid_q, rsp_valid_d;
    logic [DW-1:0]   rdata_q, rdata_d;
    logic            owner_q, owner_d;
    logic            rd_q, rd_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
    logic            last_grant_q, last_grant_d;
`endif

    logic [1:0]      grant;
    logic            sel;

    always_comb begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
        if (req_valid[0])      grant = 2'b01;
        else if (req_valid[1]) grant = 2'b10;
        else                   grant = 2'b00;
`else
        case (req_valid)
            2'b11:   grant = last_grant_q ? 2'b01 : 2'b10;
            2'b01:   grant = 2'b01;
            2'b10:   grant = 2'b10;
            default: grant = 2'b00;
        endcase
`endif
        sel = grant[1];
    end

    always_comb begin
        state_d     = state_q;
        csb_d       = csb_q;
        web_d       = web_q;
        wmask_d     = wmask_q;
        addr_d      = addr_q;
        din_d       = din_q;
        rsp_valid_d = '0;
        rdata_d     = rdata_q;
        owner_d     = owner_q;
        rd_d        = rd_q;
`ifndef SRAM_ARB_FIXED_PRIO_EN
        last_grant_d = last_grant_q;
`endif
        case (state_q)
            IDLE: begin
                if (|grant) begin
                    addr_d  = sel ? req_addr[AW +: AW]   : req_addr[0 +: AW];
                    wmask_d = sel ? req_wmask[MW +: MW]  : req_wmask[0 +: MW];
                    din_d   = sel ? req_wdata[DW +: DW]  : req_wdata[0 +: DW];
                    web_d   = ~req_we[sel];
                    rd_d    = ~req_we[sel];
                    csb_d   = 1'b0;
                    owner_d = sel;
`ifndef SRAM_ARB_FIXED_PRIO_EN
                    last_grant_d = sel;
`endif
                    state_d = ACCESS;
                end
            end
            ACCESS: begin
                csb_d   = 1'b1;
                web_d   = 1'b1;
                state_d = CAPTURE;
            end
            CAPTURE: begin
                // Macro output is valid this cycle; write accesses leave rdata untouched.
                if (rd_q) rdata_d = sram_dout;
                rsp_valid_d[owner_q] = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            csb_q       <= 1'b1;
            web_q       <= 1'b1;
            wmask_q     <= '0;
            addr_q      <= '0;
            din_q       <= '0;
            rsp_valid_q <= '0;
            rdata_q     <= '0;
            owner_q     <= 1'b0;
            rd_q        <= 1'b0;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant_q <= 1'b1;
`endif
        end else begin
            state_q     <= state_d;
            csb_q       <= csb_d;
            web_q       <= web_d;
            wmask_q     <= wmask_d;
            addr_q      <= addr_d;
            din_q       <= din_d;
            rsp_valid_q <= rsp_valid_d;
            rdata_q     <= rdata_d;
            owner_q     <= owner_d;
            rd_q        <= rd_d;
`ifndef SRAM_ARB_FIXED_PRIO_EN
            last_grant_q <= last_grant_d;
`endif
        end
    end

    assign req_ready  = (state_q == IDLE) ? grant : 2'b00;
    assign busy       = (state_q != IDLE);
    assign rsp_valid  = rsp_valid_q;
    assign rsp_rdata  = rdata_q;
    assign sram_csb   = csb_q;
    assign sram_web   = web_q;
    assign sram_wmask = wmask_q;
    assign sram_addr  = addr_q;
    assign sram_din   = din_q;

endmodule

// File: tb/tb_sram_port_arbiter.sv
// Bench for sram_port_arbiter: directed scenarios plus random traffic against a slot-based reference.
// Honours SRAM_ARB_FIXED_PRIO_EN to pick the expected arbitration rule.
module tb_sram_port_arbiter;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst;
    logic [1:0]  req_valid, req_ready, req_we, rsp_valid;
    logic [15:0] req_addr;
    logic [7:0]  req_wmask;
    logic [63:0] req_wdata;
    logic [31:0] rsp_rdata, sram_din, sram_dout;
    logic        busy, sram_csb, sram_web;
    logic [3:0]  sram_wmask;
    logic [7:0]  sram_addr;

    sram_port_arbiter #(.AW(8), .DW(32), .MW(4)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
        .req_addr(req_addr), .req_wmask(req_wmask), .req_wdata(req_wdata),
        .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata), .busy(busy),
        .sram_csb(sram_csb), .sram_web(sram_web), .sram_wmask(sram_wmask),
        .sram_addr(sram_addr), .sram_din(sram_din), .sram_dout(sram_dout)
    );

    // Behavioural macro: command sampled on the edge, dout valid the following cycle.
    logic [31:0] mem [256];
    initial for (int i = 0; i < 256; i++) mem[i] = '0;
    always @(posedge clk) begin
        if (!sram_csb) begin
            if (!sram_web) begin
                for (int b = 0; b < 4; b++)
                    if (sram_wmask[b]) mem[sram_addr][b*8 +: 8] <= sram_din[b*8 +: 8];
                sram_dout <= $urandom;
            end else begin
                sram_dout <= mem[sram_addr];
            end
        end
    end

    int          checks = 0;
    int          errors = 0;

    // Reference: each accept reserves a 3-cycle slot; response lands at accept+3.
    logic [31:0] ref_mem [256];
    int          cyc, free_at, rsp_at, csb_at, acc_cyc, acc_who;
    bit          prev_rst, last, pend_owner, pend_read, acc_flag, rsp_flag, cmd_we;
    logic [31:0] pend_data, ref_rdata, cmd_din;
    logic [7:0]  cmd_addr;
    logic [3:0]  cmd_mask;
    logic [1:0]  obs_ready, obs_rsp;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        int       w;
        bit       idle;
        logic [1:0] ready_exp;
        @(negedge clk);
        if (prev_rst) begin
            free_at = cyc; rsp_at = -1; csb_at = -1; last = 1'b1; ref_rdata = '0;
            chk("rst_addr", sram_addr, 0);
            chk("rst_din", sram_din, 0);
            chk("rst_wmask", sram_wmask, 0);
        end
        if (cyc == rsp_at && pend_read) ref_rdata = pend_data;
        idle = (cyc >= free_at);
        w = -1;
        if (req_valid == 2'b11) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
            w = 0;
`else
            w = last ? 0 : 1;
`endif
        end else if (req_valid[0]) w = 0;
        else if (req_valid[1]) w = 1;
        ready_exp = (idle && w >= 0) ? 2'(1 << w) : 2'b00;
        obs_ready = req_ready;
        obs_rsp   = rsp_valid;
        chk("ready", req_ready, ready_exp);
        chk("busy", busy, !idle);
        chk("csb", sram_csb, cyc != csb_at);
        chk("web", sram_web, (cyc == csb_at) ? !cmd_we : 1'b1);
        if (cyc == csb_at) begin
            chk("cmd_addr", sram_addr, cmd_addr);
            chk("cmd_din", sram_din, cmd_din);
            chk("cmd_wmask", sram_wmask, cmd_mask);
        end
        chk("rsp_valid", rsp_valid, (cyc == rsp_at) ? (pend_owner ? 2'b10 : 2'b01) : 2'b00);
        chk("rsp_rdata", rsp_rdata, ref_rdata);
        rsp_flag = (cyc == rsp_at);
        acc_flag = 1'b0;
        if (!rst && idle && w >= 0) begin
            acc_flag = 1'b1; acc_who = w; acc_cyc = cyc; last = w[0];
            free_at = cyc + 3; csb_at = cyc + 1; rsp_at = cyc + 3;
            pend_owner = w[0];
            cmd_we   = req_we[w];
            cmd_addr = req_addr[w*8 +: 8];
            cmd_din  = req_wdata[w*32 +: 32];
            cmd_mask = req_wmask[w*4 +: 4];
            pend_read = !cmd_we;
            if (cmd_we) begin
                for (int b = 0; b < 4; b++)
                    if (cmd_mask[b]) ref_mem[cmd_addr][b*8 +: 8] = cmd_din[b*8 +: 8];
            end else begin
                pend_data = ref_mem[cmd_addr];
            end
        end
        prev_rst = rst;
        cyc++;
        @(posedge clk);
        #1;
    endtask

    task automatic set_req(input int r, input bit we, input logic [7:0] a,
                           input logic [3:0] m, input logic [31:0] d);
        req_we[r] = we;
        req_addr[r*8 +: 8] = a;
        req_wmask[r*4 +: 4] = m;
        req_wdata[r*32 +: 32] = d;
    endtask

    task automatic issue(input int r, input bit we, input logic [7:0] a,
                         input logic [3:0] m, input logic [31:0] d);
        bit got = 1'b0;
        set_req(r, we, a, m, d);
        req_valid[r] = 1'b1;
        for (int i = 0; i < 12 && !got; i++) begin
            tick();
            if (acc_flag && acc_who == r) got = 1'b1;
        end
        req_valid[r] = 1'b0;
        chk("accept_seen", got, 1);
    endtask

    task automatic wait_rsp(output int lat);
        bit seen = 1'b0;
        lat = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            tick();
            lat++;
            if (rsp_flag) seen = 1'b1;
        end
        chk("rsp_seen", seen, 1);
    endtask

    initial begin
        int lat, prev_acc, nacc, r1_hits;
        logic [1:0] exp_g;

        for (int i = 0; i < 256; i++) ref_mem[i] = '0;
        cyc = 0; free_at = 0; rsp_at = -1; csb_at = -1; acc_cyc = 0; acc_who = 0;
        last = 1'b1; prev_rst = 1'b1; ref_rdata = '0; pend_read = 1'b0; pend_owner = 1'b0;
        cmd_we = 1'b0; cmd_addr = '0; cmd_din = '0; cmd_mask = '0; pend_data = '0;
        rst = 1'b1; req_valid = '0; req_we = '0; req_addr = '0; req_wmask = '0; req_wdata = '0;
        @(posedge clk);
        #1;
        tick();
        rst = 1'b0;
        tick();

        // Write then read back through the other requester.
        issue(0, 1'b1, 8'h05, 4'hF, 32'hDEADBEEF);
        wait_rsp(lat);
        chk("s1_wr_lat", lat, 3);
        chk("s1_wr_rsp", obs_rsp, 2'b01);
        issue(1, 1'b0, 8'h05, 4'h0, 32'h0);
        wait_rsp(lat);
        chk("s1_rd_lat", lat, 3);
        chk("s1_rd_rsp", obs_rsp, 2'b10);
        chk("s1_rd_data", rsp_rdata, 32'hDEADBEEF);

        // Byte-masked write merge.
        issue(0, 1'b1, 8'h10, 4'hF, 32'h11223344);
        wait_rsp(lat);
        issue(0, 1'b1, 8'h10, 4'b0001, 32'hAABBCCDD);
        wait_rsp(lat);
        chk("s2_wr_rdata_hold", rsp_rdata, 32'hDEADBEEF);
        issue(0, 1'b0, 8'h10, 4'h0, 32'h0);
        wait_rsp(lat);
        chk("s2_rd_data", rsp_rdata, 32'h112233DD);

        // Both requesters continuously valid after a fresh reset.
        rst = 1'b1;
        tick();
        rst = 1'b0;
        set_req(0, 1'b0, 8'h05, 4'h0, 32'h0);
        set_req(1, 1'b0, 8'h10, 4'h0, 32'h0);
        req_valid = 2'b11;
        nacc = 0;
        prev_acc = 0;
        for (int i = 0; i < 20 && nacc < 4; i++) begin
            tick();
            if (acc_flag) begin
`ifdef SRAM_ARB_FIXED_PRIO_EN
                exp_g = 2'b01;
`else
                exp_g = (nacc % 2 == 0) ? 2'b01 : 2'b10;
`endif
                chk("s3_grant", obs_ready, exp_g);
                if (nacc > 0) chk("s3_spacing", acc_cyc - prev_acc, 3);
                prev_acc = acc_cyc;
                nacc++;
            end
        end
        chk("s3_accepts", nacc, 4);
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) tick();

        // Reset during ACCESS of a read abandons it; tie afterwards goes to requester 0.
        issue(1, 1'b0, 8'h05, 4'h0, 32'h0);
        rst = 1'b1;
        tick();
        chk("s5_csb", sram_csb, 1);
        chk("s5_busy", busy, 0);
        chk("s5_rsp", rsp_valid, 0);
        rst = 1'b0;
        req_valid = 2'b11;
        tick();
        chk("s5_tie", obs_ready, 2'b01);
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) tick();

        // Requester 1 withdraws while requester 0 is being served.
        issue(0, 1'b1, 8'h20, 4'hF, 32'hCAFE0001);
        set_req(1, 1'b0, 8'h20, 4'h0, 32'h0);
        req_valid[1] = 1'b1;
        tick();
        req_valid[1] = 1'b0;
        wait_rsp(lat);
        chk("s6_rsp", obs_rsp, 2'b01);
        r1_hits = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            r1_hits += int'(obs_rsp[1]);
        end
        chk("s6_no_r1", r1_hits, 0);

        // Random traffic with occasional withdrawals and resets.
        for (int n = 0; n < 400; n++) begin
            for (int r = 0; r < 2; r++) begin
                if (!req_valid[r]) begin
                    if ($urandom_range(0, 2) == 0) begin
                        set_req(r, 1'($urandom_range(0, 1)),
                                ($urandom_range(0, 7) == 0) ? 8'($urandom) : 8'($urandom_range(0, 15)),
                                4'($urandom), $urandom);
                        req_valid[r] = 1'b1;
                    end
                end else if ($urandom_range(0, 15) == 0) begin
                    req_valid[r] = 1'b0;
                end
            end
            rst = ($urandom_range(0, 79) == 0);
            tick();
            if (acc_flag) req_valid[acc_who] = 1'b0;
        end
        rst = 1'b0;
        req_valid = 2'b00;
        for (int i = 0; i < 4; i++) tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
